aes_key_schedule: RTL

- Iterative AES key expansion engine for AES-128, AES-192 and AES-256, selected per key by a run-time mode input.
- Generates one 32-bit schedule word per cycle using a single shared sub_word instance (4 S-boxes).
- Stores the full schedule in an internal word buffer and serves 128-bit round keys by index through a registered read port.
- Sits between the key-load interface and the AES round datapath, which fetches round keys by round number.

---
 rtl/aes_key_schedule_if.sv | 27 ++
 rtl/aes_key_schedule.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_if.sv
// Key-load, status and round-key read signals of the AES key schedule engine.
// Key load: a key transfers on a rising edge where key_valid && key_ready; key_valid may be held, key_ready never waits on key_valid.
interface aes_key_schedule_if;
    logic         key_valid;
    logic         key_ready;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         key_err;
    logic         keys_valid;
    logic [3:0]   num_rounds;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rk_data_vld;

    modport master (
        output key_valid, key_len, key, rk_rd_en, rk_idx,
        input  key_ready, busy, done, key_err, keys_valid, num_rounds, rk_data, rk_data_vld
    );

    modport slave (
        input  key_valid, key_len, key, rk_rd_en, rk_idx,
        output key_ready, busy, done, key_err, keys_valid, num_rounds, rk_data, rk_data_vld
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle into a
// word buffer, with a registered 128-bit round-key read port.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                rst,
    aes_key_schedule_if.slave   bus,
    output logic                state_dbg
);
    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int DEPTH  = 4 * (MAX_NK + 7);
    localparam int IW     = $clog2(DEPTH);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state, state_n;
    logic [31:0]     w_mem [DEPTH];
    logic [IW-1:0]   i;
    logic [2:0]      j;
    logic [3:0]      nk;
    logic [7:0]      rcon;
    logic [3:0]      nk_sel;
    logic            mode_ok;
    logic            accept, reject, last;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   rd_base;
    logic [31:0]     prev_w, back_w, sw_in, sw_out, temp;
    logic            done_r, key_err_r, keys_valid_r;
    logic [3:0]      num_rounds_r;
    logic [127:0]    rk_data_r;
    logic            rk_data_vld_r;

    always_comb begin
        nk_sel = 4'd0;
        case (bus.key_len)
            2'd0:    nk_sel = 4'd4;
            2'd1:    nk_sel = 4'd6;
            2'd2:    nk_sel = 4'd8;
            default: nk_sel = 4'd0;
        endcase
    end

    assign mode_ok  = (bus.key_len != 2'd3) && (int'(nk_sel) * 32 <= MAX_KEY_BITS);
    // Last word index 4*(Nr+1)-1 falls out of Nr without a multiplier.
    assign last_idx = IW'({num_rounds_r, 2'b11});
    assign rd_base  = IW'({bus.rk_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    if (mode_ok) begin
                        accept  = 1'b1;
                        state_n = EXPAND;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            EXPAND: begin
                if (i == last_idx) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // One shared SubWord: its input is rotated only on the Rcon step.
    always_comb begin
        prev_w = w_mem[i - IW'(1)];
        back_w = w_mem[i - IW'(nk)];
        sw_in  = (j == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sw_out = sub_word(sw_in);
        if (j == 3'd0)                         temp = sw_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)      temp = sw_out;
        else                                   temp = prev_w;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < MAX_NK; k++)
                if (k < int'(nk_sel)) w_mem[IW'(k)] <= bus.key[255 - 32*k -: 32];
        end else if (state == EXPAND) begin
            w_mem[i] <= back_w ^ temp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_r        <= 1'b0;
            key_err_r     <= 1'b0;
            keys_valid_r  <= 1'b0;
            num_rounds_r  <= 4'd0;
            rcon          <= 8'h01;
            i             <= '0;
            j             <= 3'd0;
            nk            <= 4'd0;
            rk_data_r     <= '0;
            rk_data_vld_r <= 1'b0;
        end else begin
            done_r    <= last;
            key_err_r <= reject;
            if (accept) begin
                i            <= IW'(nk_sel);
                j            <= 3'd0;
                nk           <= nk_sel;
                rcon         <= 8'h01;
                num_rounds_r <= nk_sel + 4'd6;
                keys_valid_r <= 1'b0;
            end else if (reject) begin
                keys_valid_r <= 1'b0;
            end else if (state == EXPAND) begin
                i <= i + IW'(1);
                j <= (j == 3'(nk - 4'd1)) ? 3'd0 : j + 3'd1;
                if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (last)      keys_valid_r <= 1'b1;
            end
            // Uses pre-edge keys_valid/num_rounds, so a read racing a new load sees the old schedule.
            rk_data_vld_r <= bus.rk_rd_en;
            if (bus.rk_rd_en) begin
                if (keys_valid_r && bus.rk_idx <= num_rounds_r)
                    rk_data_r <= {w_mem[rd_base], w_mem[rd_base + IW'(1)],
                                  w_mem[rd_base + IW'(2)], w_mem[rd_base + IW'(3)]};
                else
                    rk_data_r <= '0;
            end
        end
    end

    assign bus.key_ready   = (state == IDLE);
    assign bus.busy        = (state == EXPAND);
    assign bus.done        = done_r;
    assign bus.key_err     = key_err_r;
    assign bus.keys_valid  = keys_valid_r;
    assign bus.num_rounds  = num_rounds_r;
    assign bus.rk_data     = rk_data_r;
    assign bus.rk_data_vld = rk_data_vld_r;
    assign state_dbg       = (state == EXPAND);
endmodule
